pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 17 +
 rtl/hz_scoreboard.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the hazard controller and its
// scoreboard.
package pipe_pkg;

   // Architectural register index width (16 registers).
   localparam int REG_IDX_W = 4;

   // "Always" condition code; any other condition depends on the flags.
   localparam logic [3:0] COND_AL = 4'b1110;

   // Branch-flush sequencer states.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: one busy bit per architectural register. A register is busy
// from the issue of its writer until that writer retires. The register file
// writes through, so a register retiring this cycle is no longer a hazard.
module hz_scoreboard
   import pipe_pkg::*;
#(
   parameter int NUM_REGS = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic                 id_valid,
   input  logic                 id_use_rn,
   input  logic [REG_IDX_W-1:0] id_rn,
   input  logic                 id_use_rm,
   input  logic [REG_IDX_W-1:0] id_rm,
   output logic                 reg_hazard
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] busy_eff;

   // Decode the retiring register into a one-hot clear mask.
   always_comb begin
      clr_mask = '0;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
   end

   // Decode the issuing destination into a one-hot set mask.
   always_comb begin
      set_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
   end

   assign busy_eff   = busy & ~clr_mask;
   assign reg_hazard = id_valid & ((id_use_rn & busy_eff[id_rn]) |
                                   (id_use_rm & busy_eff[id_rm]));

   // Busy update: a new writer issued to a register that retires in the same
   // cycle keeps it busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_eff | set_mask;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-stage interlock. Stalls on register RAW and flag
// hazards, kills FLUSH_CYCLES issue slots after a taken branch (branch flush
// wins over a stall). All outputs are combinational from inputs and state.
// Optional build macro HAZ_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int NUM_REGS          = 16,
   parameter int FLUSH_CYCLES      = 2,
   parameter int MAX_FLAG_INFLIGHT = 3
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rn,
   input  logic [REG_IDX_W-1:0] id_rm,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_use_rn,
   input  logic                 id_use_rm,
   input  logic                 id_wr_en,
   input  logic [3:0]           id_cond,
   input  logic                 id_set_flags,
   input  logic                 ex_branch_taken,
   input  logic                 wb_valid,
   input  logic                 wb_wr_en,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic                 wb_set_flags,
`ifdef HAZ_PERF_EN
   output logic [15:0]          stall_count,
   output logic [15:0]          flush_count,
`endif
   output logic                 issue,
   output logic                 stall_pc,
   output logic                 stall_id,
   output logic                 flush_id,
   output logic                 flush_ex
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam int FL_W = $clog2(MAX_FLAG_INFLIGHT + 1);
   localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_ONE     = FC_W'(1);
   localparam logic [FL_W-1:0] FLAG_MAX   = FL_W'(MAX_FLAG_INFLIGHT);
   localparam logic [FL_W-1:0] FL_ONE     = FL_W'(1);

   hz_state_e       state, state_nxt;
   logic [FC_W-1:0] fcnt, fcnt_nxt;
   logic [FL_W-1:0] flag_cnt;
   logic            flush_req;
   logic            reg_hazard;
   logic            flag_hazard;
   logic            hazard;
   logic            flag_inc;
   logic            flag_dec;

   hz_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .set_en     (issue & id_wr_en),
      .set_idx    (id_rd),
      .clr_en     (wb_valid & wb_wr_en),
      .clr_idx    (wb_rd),
      .id_valid   (id_valid),
      .id_use_rn  (id_use_rn),
      .id_rn      (id_rn),
      .id_use_rm  (id_use_rm),
      .id_rm      (id_rm),
      .reg_hazard (reg_hazard)
   );

   // Conditional instructions wait for all in-flight flag writers; a new flag
   // writer waits when the in-flight limit is already reached.
   assign flag_hazard = (id_valid & (id_cond != COND_AL) & (flag_cnt != '0)) |
                        (id_set_flags & (flag_cnt == FLAG_MAX));
   assign hazard      = reg_hazard | flag_hazard;

   // Outputs are forced to their idle values while reset is held.
   assign flush_id = ~reset & flush_req;
   assign issue    = ~reset & id_valid & ~hazard & ~flush_req;
   assign stall_pc = ~reset & hazard & ~flush_req;
   assign stall_id = stall_pc;
   assign flush_ex = ~issue;

   assign flag_inc = issue & id_set_flags;
   assign flag_dec = wb_valid & wb_set_flags;

   // Flush sequencer state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Flush sequencer next state: the branch cycle itself is the first killed
   // slot, the FLUSH state covers the remaining FLUSH_CYCLES-1.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      flush_req = 1'b0;
      case (state)
         ST_RUN: begin
            if (ex_branch_taken) begin
               flush_req = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = ST_FLUSH;
                  fcnt_nxt  = FLUSH_LAST;
               end
            end
         end
         ST_FLUSH: begin
            flush_req = 1'b1;
            fcnt_nxt  = fcnt - FC_ONE;
            if (fcnt <= FC_ONE) begin
               state_nxt = ST_RUN;
               fcnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            fcnt_nxt  = '0;
         end
      endcase
   end

   // In-flight flag-writer count; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_cnt <= '0;
      end else if (flag_inc && !flag_dec) begin
         if (flag_cnt != FLAG_MAX) flag_cnt <= flag_cnt + FL_ONE;
      end else if (flag_dec && !flag_inc) begin
         if (flag_cnt != '0) flag_cnt <= flag_cnt - FL_ONE;
      end
   end

`ifdef HAZ_PERF_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating counts of stalled and flushed decode cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_id) stall_count <= sat_inc(stall_count);
         if (flush_id) flush_count <= sat_inc(flush_count);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random traffic, all
// compared against a behavioural model of the interlock rules.
module tb_pipe_hazard_ctrl;

   localparam int NUM_REGS          = 16;
   localparam int FLUSH_CYCLES      = 2;
   localparam int MAX_FLAG_INFLIGHT = 3;
   localparam logic [3:0] AL        = 4'b1110;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [3:0] id_rn, id_rm, id_rd;
   logic       id_use_rn, id_use_rm, id_wr_en;
   logic [3:0] id_cond;
   logic       id_set_flags;
   logic       ex_branch_taken;
   logic       wb_valid, wb_wr_en;
   logic [3:0] wb_rd;
   logic       wb_set_flags;
   logic       issue, stall_pc, stall_id, flush_id, flush_ex;
`ifdef HAZ_PERF_EN
   logic [15:0] stall_count, flush_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model state
   bit m_busy [NUM_REGS];
   int m_fcnt;
   int m_flush_left;
   int m_stall_cnt;
   int m_flush_cnt;
   bit e_issue, e_stall, e_flush;

   typedef struct {
      logic [3:0] rd;
      logic       wr;
      logic       sf;
   } instr_t;
   instr_t inflight[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .NUM_REGS          (NUM_REGS),
      .FLUSH_CYCLES      (FLUSH_CYCLES),
      .MAX_FLAG_INFLIGHT (MAX_FLAG_INFLIGHT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_rn           (id_rn),
      .id_rm           (id_rm),
      .id_rd           (id_rd),
      .id_use_rn       (id_use_rn),
      .id_use_rm       (id_use_rm),
      .id_wr_en        (id_wr_en),
      .id_cond         (id_cond),
      .id_set_flags    (id_set_flags),
      .ex_branch_taken (ex_branch_taken),
      .wb_valid        (wb_valid),
      .wb_wr_en        (wb_wr_en),
      .wb_rd           (wb_rd),
      .wb_set_flags    (wb_set_flags),
`ifdef HAZ_PERF_EN
      .stall_count     (stall_count),
      .flush_count     (flush_count),
`endif
      .issue           (issue),
      .stall_pc        (stall_pc),
      .stall_id        (stall_id),
      .flush_id        (flush_id),
      .flush_ex        (flush_ex)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_fcnt       = 0;
      m_flush_left = 0;
      m_stall_cnt  = 0;
      m_flush_cnt  = 0;
      inflight.delete();
   endtask

   // Expected outputs for the current inputs from the interlock rules.
   task automatic predict();
      bit clr, hz_rn, hz_rm, reg_hz, flag_hz, hz;
      clr     = wb_valid && wb_wr_en;
      hz_rn   = id_use_rn && m_busy[id_rn] && !(clr && wb_rd == id_rn);
      hz_rm   = id_use_rm && m_busy[id_rm] && !(clr && wb_rd == id_rm);
      reg_hz  = id_valid && (hz_rn || hz_rm);
      flag_hz = (id_valid && id_cond != AL && m_fcnt != 0) ||
                (id_set_flags && m_fcnt == MAX_FLAG_INFLIGHT);
      hz      = reg_hz || flag_hz;
      e_flush = (m_flush_left > 0) || ex_branch_taken;
      e_issue = id_valid && !hz && !e_flush;
      e_stall = hz && !e_flush;
   endtask

   // Model state after the clock edge.
   task automatic advance();
      bit inc, dec;
      instr_t it;
      if (wb_valid && wb_wr_en) m_busy[wb_rd] = 1'b0;
      if (e_issue && id_wr_en)  m_busy[id_rd] = 1'b1;
      inc = e_issue && id_set_flags;
      dec = wb_valid && wb_set_flags;
      if (inc && !dec) m_fcnt++;
      else if (dec && !inc && m_fcnt > 0) m_fcnt--;
      if (m_flush_left > 0) m_flush_left--;
      else if (ex_branch_taken) m_flush_left = FLUSH_CYCLES - 1;
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_flush && m_flush_cnt < 65535) m_flush_cnt++;
      if (e_issue) begin
         it.rd = id_rd;
         it.wr = id_wr_en;
         it.sf = id_set_flags;
         inflight.push_back(it);
      end
   endtask

   // One decode cycle: check against the model and, where given (>=0),
   // against literal expectations for issue / stall_id / flush_id.
   task automatic step_x(input string tag, input int ei, input int es, input int ef);
      #1;
      predict();
      chk({tag, ".issue"},    issue,    e_issue);
      chk({tag, ".stall_pc"}, stall_pc, e_stall);
      chk({tag, ".stall_id"}, stall_id, e_stall);
      chk({tag, ".flush_id"}, flush_id, e_flush);
      chk({tag, ".flush_ex"}, flush_ex, !e_issue);
      if (ei >= 0) chk({tag, ".lit_issue"}, issue,    ei[0]);
      if (es >= 0) chk({tag, ".lit_stall"}, stall_id, es[0]);
      if (ef >= 0) chk({tag, ".lit_flush"}, flush_id, ef[0]);
      @(posedge clk);
      advance();
      #1;
`ifdef HAZ_PERF_EN
      chk16({tag, ".stall_count"}, stall_count, 16'(m_stall_cnt));
      chk16({tag, ".flush_count"}, flush_count, 16'(m_flush_cnt));
`endif
      @(negedge clk);
   endtask

   task automatic step(input string tag);
      step_x(tag, -1, -1, -1);
   endtask

   task automatic set_id(input bit v, input int rn, input bit urn, input int rm,
                         input bit urm, input int rd, input bit wr,
                         input logic [3:0] cond, input bit sf);
      id_valid     = v;
      id_rn        = 4'(rn);
      id_use_rn    = urn;
      id_rm        = 4'(rm);
      id_use_rm    = urm;
      id_rd        = 4'(rd);
      id_wr_en     = wr;
      id_cond      = cond;
      id_set_flags = sf;
   endtask

   task automatic set_wb(input bit v, input int rd, input bit wr, input bit sf);
      wb_valid     = v;
      wb_rd        = 4'(rd);
      wb_wr_en     = wr;
      wb_set_flags = sf;
   endtask

   // Reset pulse with busy inputs, checking the forced output values.
   task automatic hw_reset(input string tag);
      set_id(1, 1, 1, 2, 1, 3, 1, 4'b0000, 1);
      ex_branch_taken = 1'b1;
      reset = 1'b1;
      #1;
      chk({tag, ".issue"},    issue,    1'b0);
      chk({tag, ".stall_pc"}, stall_pc, 1'b0);
      chk({tag, ".stall_id"}, stall_id, 1'b0);
      chk({tag, ".flush_id"}, flush_id, 1'b0);
      chk({tag, ".flush_ex"}, flush_ex, 1'b1);
`ifdef HAZ_PERF_EN
      chk16({tag, ".stall_count"}, stall_count, 16'd0);
      chk16({tag, ".flush_count"}, flush_count, 16'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      ex_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, AL, 0);
      model_reset();
   endtask

   initial begin
      reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, AL, 0);
      set_wb(0, 0, 0, 0);
      ex_branch_taken = 1'b0;
      model_reset();
      @(negedge clk);
      hw_reset("reset0");

      // RAW on r3: stall until the writer retires, issue in the retire cycle
      set_id(1, 0, 0, 0, 0, 3, 1, AL, 0);
      step_x("raw_issue", 1, 0, 0);
      set_id(1, 3, 1, 0, 0, 0, 0, AL, 0);
      step_x("raw_stall1", 0, 1, 0);
      step_x("raw_stall2", 0, 1, 0);
      set_wb(1, 3, 1, 0);
      step_x("raw_wb", 1, 0, 0);
      set_wb(0, 0, 0, 0);

      // Taken branch: two killed slots, branch ignored during flush
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 0);
      ex_branch_taken = 1'b1;
      step_x("br_T", 0, 0, 1);
      step_x("br_T1", 0, 0, 1);
      ex_branch_taken = 1'b0;
      step_x("br_T2", 1, 0, 0);

      // Flags: conditional waits for the flag writer, AL does not
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 1);
      step_x("fl_set", 1, 0, 0);
      set_id(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
      step_x("fl_stall", 0, 1, 0);
      set_wb(1, 0, 0, 1);
      step_x("fl_wbcyc", 0, 1, 0);
      set_wb(0, 0, 0, 0);
      step_x("fl_go", 1, 0, 0);
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 1);
      step_x("fl_set2", 1, 0, 0);
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 0);
      step_x("fl_al", 1, 0, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, AL, 0);
      set_wb(1, 0, 0, 1);
      step_x("fl_drain", 0, 0, 0);
      set_wb(0, 0, 0, 0);

      // Simultaneous set and clear of r5 leaves it busy
      set_wb(1, 5, 1, 0);
      set_id(1, 0, 0, 0, 0, 5, 1, AL, 0);
      step_x("sim_issue", 1, 0, 0);
      set_wb(0, 0, 0, 0);
      set_id(1, 0, 0, 5, 1, 0, 0, AL, 0);
      step_x("sim_busy5", 0, 1, 0);
      set_wb(1, 5, 1, 0);
      step_x("sim_clear", 1, 0, 0);
      set_wb(0, 0, 0, 0);

      // Flag writer limit
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 1);
      step_x("fmax_1", 1, 0, 0);
      step_x("fmax_2", 1, 0, 0);
      step_x("fmax_3", 1, 0, 0);
      step_x("fmax_full", 0, 1, 0);
      set_wb(1, 0, 0, 1);
      step_x("fmax_wbcyc", 0, 1, 0);
      set_wb(0, 0, 0, 0);
      step_x("fmax_room", 1, 0, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, AL, 0);
      set_wb(1, 0, 0, 1);
      step_x("fmax_drain1", 0, 0, 0);
      step_x("fmax_drain2", 0, 0, 0);
      step_x("fmax_drain3", 0, 0, 0);
      set_wb(0, 0, 0, 0);

      // Reset in the middle of a flush clears everything
      set_id(1, 0, 0, 0, 0, 7, 1, AL, 1);
      step_x("rf_pre", 1, 0, 0);
      set_id(1, 0, 0, 0, 0, 0, 0, AL, 0);
      ex_branch_taken = 1'b1;
      step_x("rf_T", 0, 0, 1);
      ex_branch_taken = 1'b0;
      hw_reset("rf_reset");
      set_id(1, 7, 1, 0, 0, 0, 0, 4'b0000, 0);
      step_x("rf_post", 1, 0, 0);

      // Three stall cycles and two flush cycles after a fresh reset
      hw_reset("perf_reset");
      set_id(1, 0, 0, 0, 0, 9, 1, AL, 0);
      step_x("perf_issue", 1, 0, 0);
      set_id(1, 9, 1, 0, 0, 0, 0, AL, 0);
      step_x("perf_st1", 0, 1, 0);
      step_x("perf_st2", 0, 1, 0);
      step_x("perf_st3", 0, 1, 0);
      ex_branch_taken = 1'b1;
      step_x("perf_fl1", 0, 0, 1);
      ex_branch_taken = 1'b0;
      step_x("perf_fl2", 0, 0, 1);
`ifdef HAZ_PERF_EN
      chk16("perf.stall_count", stall_count, 16'd3);
      chk16("perf.flush_count", flush_count, 16'd2);
`endif
      set_wb(1, 9, 1, 0);
      step("perf_clear");
      set_wb(0, 0, 0, 0);

      // Random traffic; retirements come from the model's in-flight queue
      for (int i = 0; i < 400; i++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         set_id(v, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 1) == 1) ? AL : 4'($urandom_range(0, 15)),
                v && ($urandom_range(0, 3) == 0));
         if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
            instr_t h;
            h = inflight.pop_front();
            set_wb(1, h.rd, h.wr, h.sf);
         end else begin
            set_wb(0, $urandom_range(0, 15), 1, 1);
         end
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
